// File: rtl/rgb2grey_stream.sv
// Streaming RGB-to-grey converter: programmable Q0.FRAC weights, optional round-half-up,
// two register stages under a valid/ready handshake with full backpressure and a per-frame beat counter.
module rgb2grey_stream #(
  parameter int unsigned      CW    = 8,
  parameter int unsigned      FRAC  = 8,
  parameter logic [FRAC-1:0]  R_DEF = 8'h4C,
  parameter logic [FRAC-1:0]  G_DEF = 8'h96,
  parameter logic [FRAC-1:0]  B_DEF = 8'h1D,
  parameter int unsigned      CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*CW-1:0]   in_pixel,
  input  logic              in_last,
  input  logic              round_en,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [FRAC-1:0]   cfg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_grey,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned PW = CW + FRAC;
  localparam int unsigned SW = PW + 2;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high; a source
  // holds valid and payload until that edge. The whole pipe moves only when the output slot
  // is empty or being drained, so in_ready depends on out_ready/out_valid but never on in_valid.
  logic w_en;
  logic w_accept;

  logic [FRAC-1:0] r_cr, r_cg, r_cb;

  logic          r_v1;
  logic [PW-1:0] r_pr, r_pg, r_pb;
  logic          r_rnd1;
  logic          r_last1;

  logic             r_v2;
  logic [CW-1:0]    r_grey;
  logic             r_last2;
  logic [CNT_W-1:0] r_count;

  logic [CW-1:0] w_r, w_g, w_b;
  logic [PW-1:0] w_pr, w_pg, w_pb;
  logic [SW-1:0] w_rnd_add;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_shift;
  logic [CW-1:0] w_grey;

  assign w_en     = !r_v2 || out_ready;
  assign w_accept = in_valid && w_en;
  assign in_ready = w_en;

  assign w_r = in_pixel[3*CW-1:2*CW];
  assign w_g = in_pixel[2*CW-1:CW];
  assign w_b = in_pixel[CW-1:0];

  assign w_pr = {{CW{1'b0}}, r_cr} * {{FRAC{1'b0}}, w_r};
  assign w_pg = {{CW{1'b0}}, r_cg} * {{FRAC{1'b0}}, w_g};
  assign w_pb = {{CW{1'b0}}, r_cb} * {{FRAC{1'b0}}, w_b};

  assign w_rnd_add = r_rnd1 ? (SW'(1) << (FRAC - 1)) : '0;
  assign w_sum     = {2'b00, r_pr} + {2'b00, r_pg} + {2'b00, r_pb} + w_rnd_add;
  assign w_shift   = w_sum >> FRAC;
  // Anything at or above 2^CW clips to full scale.
  assign w_grey    = (|w_shift[SW-1:CW]) ? {CW{1'b1}} : w_shift[CW-1:0];

  // Coefficient writes land at the edge, so a pixel accepted on that same edge sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cr <= R_DEF;
      r_cg <= G_DEF;
      r_cb <= B_DEF;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    r_cr <= cfg_data;
        2'd1:    r_cg <= cfg_data;
        2'd2:    r_cb <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_pr    <= '0;
      r_pg    <= '0;
      r_pb    <= '0;
      r_rnd1  <= 1'b0;
      r_last1 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_pr    <= w_pr;
        r_pg    <= w_pg;
        r_pb    <= w_pb;
        r_rnd1  <= round_en;
        r_last1 <= in_last;
      end
    end
  end

  // Bubbles leave the output payload untouched; only out_valid follows them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_grey  <= '0;
      r_last2 <= 1'b0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_grey  <= w_grey;
        r_last2 <= r_last1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_v2 && out_ready) begin
      if (r_last2) begin
        r_count <= '0;
      end else if (!(&r_count)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_v2;
  assign out_grey  = r_grey;
  assign out_last  = r_last2;
  assign out_count = r_count;

endmodule

// File: tb/tb_rgb2grey_stream.sv
// Bench for rgb2grey_stream: arithmetic reference model with an expected queue, one negedge
// compare process, directed literal cases and a randomized backpressure/config stream.
module tb_rgb2grey_stream;

  localparam int CW    = 8;
  localparam int FRAC  = 8;
  localparam int CNT_W = 4;
  localparam int W     = 32 + 1 + CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3*CW-1:0]   in_pixel;
  logic              in_last;
  logic              round_en;
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [FRAC-1:0]   cfg_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_grey;
  logic              out_last;
  logic [CNT_W-1:0]  out_count;

  rgb2grey_stream #(.CW(CW), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_last(in_last), .round_en(round_en),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_grey(out_grey),
    .out_last(out_last), .out_count(out_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  int            m_cr, m_cg, m_cb;
  int            m_cnt;
  int            cyc;
  bit            prev_stall;
  logic [CW-1:0] prev_grey;
  logic          prev_last;
  int            n_out;
  int            last_grey;
  bit            last_last;
  bit            lat_exact;
  logic [W-1:0]  mon_e;
  int            mon_lat;
  int            n_checks;
  int            n_pass;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Weighted sum straight from the definition, clipped to full scale.
  function automatic int model_grey(input int r, input int g, input int b,
                                    input int cr, input int cg, input int cb, input bit rnd);
    int s;
    s = cr * r + cg * g + cb * b + (rnd ? (1 << (FRAC - 1)) : 0);
    s = s / (1 << FRAC);
    if (s > (1 << CW) - 1) s = (1 << CW) - 1;
    return s;
  endfunction

  task automatic apply_reset_model();
    exp_q.delete();
    m_cnt      = 0;
    m_cr       = 'h4C;
    m_cg       = 'h96;
    m_cb       = 'h1D;
    prev_stall = 1'b0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      check("in_ready", in_ready, (!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_grey", out_grey, prev_grey);
        check("stall_last", out_last, prev_last);
      end
      check("out_count", out_count, m_cnt);
      if (out_valid) begin
        check("spurious_valid", exp_q.size() > 0, 1);
        if (out_ready && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("grey", out_grey, mon_e[CW-1:0]);
          check("last", out_last, mon_e[CW]);
          mon_lat = cyc - int'(mon_e[W-1:CW+1]);
          if (lat_exact) check("latency", mon_lat, 2);
          else           check("latency_min", mon_lat >= 2, 1);
          if (mon_e[CW])                      m_cnt = 0;
          else if (m_cnt < (1 << CNT_W) - 1)  m_cnt++;
          n_out++;
          last_grey = out_grey;
          last_last = out_last;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({32'(cyc), in_last,
          CW'(model_grey(int'(in_pixel[3*CW-1 -: CW]), int'(in_pixel[2*CW-1 -: CW]),
                         int'(in_pixel[CW-1:0]), m_cr, m_cg, m_cb, round_en))});
      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    m_cr = int'(cfg_data);
          2'd1:    m_cg = int'(cfg_data);
          2'd2:    m_cb = int'(cfg_data);
          default: ;
        endcase
      end
      prev_stall = out_valid && !out_ready;
      prev_grey  = out_grey;
      prev_last  = out_last;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [3*CW-1:0] pix, input bit last, input bit rnd);
    bit ok = 1'b0;
    in_valid = 1'b1; in_pixel = pix; in_last = last; round_en = rnd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int exp_grey, input bit exp_last);
    int start = n_out;
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (n_out != start) begin got = 1'b1; break; end
    end
    check({name, "_arrived"}, got, 1);
    if (got) begin
      check(name, last_grey, exp_grey);
      check({name, "_last"}, last_last, exp_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [FRAC-1:0] val);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = val;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic new_payload();
    in_pixel = 24'($urandom);
    in_last  = ($urandom_range(0, 5) == 0);
    round_en = 1'($urandom_range(0, 1));
  endtask

  // Keeps valid and payload held until accepted; ready is random or the 1,0,0,1 pattern.
  task automatic run_stream(input int n_target, input int max_cyc, input bit rand_mode);
    logic [3:0] pat = 4'b1001;
    int acc = 0;
    int c = 0;
    bit was;
    in_valid = 1'b1;
    new_payload();
    while (acc < n_target && c < max_cyc) begin
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : pat[c % 4];
      if (rand_mode) begin
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_sel  = 2'($urandom_range(0, 3));
        cfg_data = FRAC'($urandom);
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      was = in_valid && in_ready;
      @(posedge clk); #1;
      c++;
      if (was) acc++;
      if ((was || !in_valid) && acc < n_target) begin
        in_valid = rand_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
        new_payload();
      end else if (acc >= n_target) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check("stream_accepts", acc, n_target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int seen;

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; n_out = 0; last_grey = 0; last_last = 0; lat_exact = 1'b1;
    in_valid = 0; in_pixel = '0; in_last = 0; round_en = 0;
    cfg_we = 0; cfg_sel = '0; cfg_data = '0; out_ready = 1'b1;
    rst = 1'b1;
    apply_reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_grey", out_grey, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Default weights, truncate then round.
    send(24'hFFFFFF, 0, 0); wait_out("trunc_white", 254, 0);
    send(24'hFF0000, 0, 0); wait_out("trunc_red", 75, 0);
    send(24'hFFFFFF, 0, 1); wait_out("round_white", 254, 0);
    send(24'hFF0000, 0, 1); wait_out("round_red", 76, 0);

    // Full-scale weights overflow and clip.
    cfg_write(0, 8'hFF); cfg_write(1, 8'hFF); cfg_write(2, 8'hFF);
    send(24'hFFFFFF, 0, 0); wait_out("sat_white", 255, 0);
    send(24'h000000, 0, 0); wait_out("sat_black", 0, 0);
    cfg_write(0, 8'h4C); cfg_write(1, 8'h96); cfg_write(2, 8'h1D);

    // Frame of 5 (after closing whatever frame was open).
    send(24'h102030, 1, 0); wait_out("close_frame", model_grey(16, 32, 48, 'h4C, 'h96, 'h1D, 0), 1);
    check("frame_start_count", out_count, 0);
    for (int i = 0; i < 4; i++) send(24'($urandom), 0, 0);
    drain();
    check("frame_count4", out_count, 4);
    send(24'h00FF00, 1, 0); wait_out("frame_last", 149, 1);
    check("frame_end_count", out_count, 0);

    // Counter saturates at 15, then a last beat clears it.
    for (int i = 0; i < 17; i++) send(24'($urandom), 0, 1);
    drain();
    check("count_saturated", out_count, (1 << CNT_W) - 1);
    send(24'h0000FF, 1, 0); wait_out("sat_last", 28, 1);
    check("count_cleared", out_count, 0);

    // Reset with two pixels stuck behind a stalled output.
    cfg_write(0, 8'h00);
    send(24'h123456, 0, 0); drain();
    check("pre_rst_count", out_count, 1);
    lat_exact = 1'b0;
    out_ready = 1'b0;
    send(24'hFFFFFF, 0, 0);
    send(24'h808080, 0, 0);
    #2 rst = 1'b1;
    apply_reset_model();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_grey", out_grey, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (out_valid) seen++; end
    check("no_stale_output", seen, 0);
    @(posedge clk); #1;
    lat_exact = 1'b1;
    send(24'hFF0000, 0, 0); wait_out("post_rst_red", 75, 0);
    send(24'h00FF00, 0, 0); wait_out("post_rst_green", 149, 0);
    send(24'h0000FF, 0, 0); wait_out("post_rst_blue", 28, 0);

    // Select 3 is ignored; a write on the accept edge applies only to later pixels.
    cfg_write(3, 8'h00);
    send(24'hFF0000, 0, 0); wait_out("sel3_ignored", 75, 0);
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'h00;
    send(24'hFF0000, 0, 0);
    cfg_we = 1'b0;
    wait_out("write_same_cycle", 75, 0);
    send(24'hFF0000, 0, 0); wait_out("write_after", 0, 0);
    cfg_write(0, 8'h30); cfg_write(1, 8'h80); cfg_write(2, 8'h40);

    // Ready pattern 1,0,0,1 with continuous input, then a long random run.
    lat_exact = 1'b0;
    run_stream(8, 200, 1'b0);
    drain();
    run_stream(400, 4000, 1'b1);
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
